mem_fill_write: RTL

Write-side counterpart to the synchronous/asynchronous accumulator readers. After reset releases, it generates `len` pseudo-random words with a linear congruential generator (LCG) and writes them to consecutive addresses of a synchronous-write RAM through a simple valid/ready write port. When the last word is accepted it asserts `done`. The accumulators can then read the RAM back and compare against the checksum this block reports.

---
 rtl/mem_fill_write_pkg.sv | 12 +
 rtl/mem_fill_write_if.sv | 13 +
 rtl/mem_fill_write_prims.sv | 43 ++++
 rtl/mem_fill_write.sv | 115 +++++++++++
 4 files changed

// File: rtl/mem_fill_write_pkg.sv
// Shared constants for the memory fill writer: LCG coefficients and FSM state encodings.
package mem_fill_pkg;

    localparam int unsigned LCG_MUL = 32'd1664525;
    localparam int unsigned LCG_INC = 32'd1013904223;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_LOAD  = 2'd1;
    localparam logic [1:0] ST_WRITE = 2'd2;
    localparam logic [1:0] ST_DONE  = 2'd3;

endpackage

// File: rtl/mem_fill_write_if.sv
// Valid/ready RAM write port: master drives request, address and data; slave returns ready.
interface mem_fill_write_if #(
    parameter int AWIDTH = 10,
    parameter int DWIDTH = 32
);
    logic              wr_en;
    logic              wr_ready;
    logic [AWIDTH-1:0] wr_addr;
    logic [DWIDTH-1:0] wr_data;

    modport master (output wr_en, output wr_addr, output wr_data, input wr_ready);
    modport slave  (input wr_en, input wr_addr, input wr_data, output wr_ready);
endinterface

// File: rtl/mem_fill_write_prims.sv
// Building blocks for the fill writer: one LCG step and the clock-enabled register primitives.
module lcg_next
    import mem_fill_pkg::*;
#(
    parameter int DWIDTH = 32
) (
    input  logic [DWIDTH-1:0] d,
    output logic [DWIDTH-1:0] q
);
    localparam logic [DWIDTH-1:0] MUL = DWIDTH'(LCG_MUL);
    localparam logic [DWIDTH-1:0] INC = DWIDTH'(LCG_INC);

    assign q = d * MUL + INC;
endmodule

module REGISTER_CE #(
    parameter int N = 1
) (
    input  logic         clk,
    input  logic         ce,
    input  logic [N-1:0] d,
    output logic [N-1:0] q
);
    always_ff @(posedge clk) begin
        if (ce) q <= d;
    end
endmodule

module REGISTER_R_CE #(
    parameter int           N    = 1,
    parameter logic [N-1:0] INIT = '0
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         ce,
    input  logic [N-1:0] d,
    output logic [N-1:0] q
);
    always_ff @(posedge clk) begin
        if (rst)     q <= INIT;
        else if (ce) q <= d;
    end
endmodule

// File: rtl/mem_fill_write.sv
// Fills a RAM with min(len, 2^AWIDTH) LCG words starting at address 0, then raises done.
// Define MEM_FILL_CHECKSUM_EN to build the running checksum of accepted words; otherwise it reads 0.
module mem_fill_write
    import mem_fill_pkg::*;
#(
    parameter int AWIDTH = 10,
    parameter int DWIDTH = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [31:0]       len,
    input  logic [DWIDTH-1:0] seed,
    mem_fill_write_if.master  wr,
    output logic              done,
    output logic [DWIDTH-1:0] checksum
);
    localparam logic [AWIDTH:0] CAP = (AWIDTH+1)'(1) << AWIDTH;

    logic [1:0]        state_q, state_d;
    logic [AWIDTH:0]   cnt_q, cnt_d;
    logic              en_q, en_d;
    logic [AWIDTH-1:0] addr_q, addr_d;
    logic [DWIDTH-1:0] data_q, data_d, data_step;
    logic              done_q, done_d;
    logic [AWIDTH:0]   eff_len;
    logic              xfer, last, load, data_ce;

    assign eff_len = (len >= 32'(CAP)) ? CAP : len[AWIDTH:0];
    assign load    = (state_q == ST_LOAD);
    assign xfer    = (state_q == ST_WRITE) && en_q && wr.wr_ready;
    assign last    = xfer && (cnt_q == (AWIDTH+1)'(1));
    assign data_ce = load || xfer;

    lcg_next #(.DWIDTH(DWIDTH)) u_lcg (
        .d (data_q),
        .q (data_step)
    );

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        en_d    = en_q;
        addr_d  = addr_q;
        data_d  = data_q;
        done_d  = done_q;
        case (state_q)
            ST_IDLE: state_d = ST_LOAD;
            ST_LOAD: begin
                cnt_d  = eff_len;
                addr_d = '0;
                data_d = seed;
                if (eff_len == '0) begin
                    state_d = ST_DONE;
                    done_d  = 1'b1;
                end else begin
                    state_d = ST_WRITE;
                    en_d    = 1'b1;
                end
            end
            ST_WRITE: begin
                if (xfer) begin
                    cnt_d  = cnt_q - 1'b1;
                    data_d = data_step;
                    // Hold the address on the final beat so a full-capacity fill never shows a wrap to 0.
                    if (last) begin
                        state_d = ST_DONE;
                        en_d    = 1'b0;
                        done_d  = 1'b1;
                    end else begin
                        addr_d = addr_q + 1'b1;
                    end
                end
            end
            default: state_d = ST_DONE;
        endcase
    end

    REGISTER_R_CE #(.N(2), .INIT(ST_IDLE)) u_state (
        .clk(clk), .rst(rst), .ce(1'b1), .d(state_d), .q(state_q)
    );
    // The remaining count is always reloaded in LOAD before it is consulted, so it needs no reset.
    REGISTER_CE #(.N(AWIDTH+1)) u_cnt (
        .clk(clk), .ce(data_ce), .d(cnt_d), .q(cnt_q)
    );
    REGISTER_R_CE #(.N(1)) u_en (
        .clk(clk), .rst(rst), .ce(1'b1), .d(en_d), .q(en_q)
    );
    REGISTER_R_CE #(.N(AWIDTH)) u_addr (
        .clk(clk), .rst(rst), .ce(data_ce), .d(addr_d), .q(addr_q)
    );
    REGISTER_R_CE #(.N(DWIDTH)) u_data (
        .clk(clk), .rst(rst), .ce(data_ce), .d(data_d), .q(data_q)
    );
    REGISTER_R_CE #(.N(1)) u_done (
        .clk(clk), .rst(rst), .ce(1'b1), .d(done_d), .q(done_q)
    );

`ifdef MEM_FILL_CHECKSUM_EN
    logic [DWIDTH-1:0] csum_q, csum_d;

    assign csum_d = csum_q + data_q;

    REGISTER_R_CE #(.N(DWIDTH)) u_csum (
        .clk(clk), .rst(rst), .ce(xfer), .d(csum_d), .q(csum_q)
    );
    assign checksum = csum_q;
`else
    assign checksum = '0;
`endif

    assign wr.wr_en   = en_q;
    assign wr.wr_addr = addr_q;
    assign wr.wr_data = data_q;
    assign done       = done_q;
endmodule
